// File: rtl/sniffer_pkg.sv
// rtl/sniffer_pkg.sv - shared types and slot geometry for the sniffer result path
package sniffer_pkg;

  typedef enum logic [2:0] {IDLE, COLLECT, FLUSH, HEADER, DONE} writer_state_t;

  localparam int SLOT_BYTES  = 1550;
  localparam int HDR_BYTES   = 4;
  localparam int MAX_PAYLOAD = SLOT_BYTES - HDR_BYTES;
  localparam int CNT_W       = $clog2(SLOT_BYTES) + 1;

  function automatic logic [3:0] byteen_for(input logic [2:0] n);
    case (n)
      3'd1:    return 4'h1;
      3'd2:    return 4'h3;
      3'd3:    return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - little-endian byte-to-word accumulator
module byte_word_packer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr,
  input  logic        push,
  input  logic        take,
  input  logic [7:0]  din,
  output logic [31:0] word_o,
  output logic [2:0]  cnt_o,
  output logic        full_o,
  output logic [31:0] merged_word_o,
  output logic [2:0]  merged_cnt_o
);

  logic [31:0] word_q, word_d, base_word;
  logic [2:0]  cnt_q, cnt_d, base_cnt;

  // clr drops the held word before this cycle's byte; take drops the result after it
  always_comb begin
    base_word     = clr ? '0 : word_q;
    base_cnt      = clr ? '0 : cnt_q;
    merged_word_o = base_word;
    merged_cnt_o  = base_cnt;
    if (push && base_cnt != 3'd4) begin
      merged_word_o[{base_cnt[1:0], 3'b000} +: 8] = din;
      merged_cnt_o = base_cnt + 3'd1;
    end
    word_d = take ? '0 : merged_word_o;
    cnt_d  = take ? '0 : merged_cnt_o;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == 3'd4);

endmodule

// File: rtl/result_packet_writer.sv
// rtl/result_packet_writer.sv - packs matched packet bytes into a result slot and
// closes the slot with a length header
module result_packet_writer
  import sniffer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              pkt_valid,
  input  logic [7:0]        pkt_data,
  input  logic              pkt_sop,
  input  logic              pkt_eop,
  input  logic              pkt_match,
  output logic              pkt_ready,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_byteen,
  input  logic              mem_waitrequest,
  output logic              inc_addr,
  output logic              pkt_truncated
);

  writer_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, data_addr;
  logic [CNT_W-1:0]  len_q, len_d, k_q, k_d;
  logic              trunc_q, trunc_d, match_q, match_d, mem_write_q, mem_write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        byteen_q, byteen_d;
  logic              pk_clr, pk_push, pk_take, pk_full;
  logic [31:0]       pk_word, mg_word;
  logic [2:0]        pk_cnt, mg_cnt;
  logic              req_free, accept;

  byte_word_packer u_packer (
    .clk(clk), .n_rst(n_rst), .clr(pk_clr), .push(pk_push), .take(pk_take),
    .din(pkt_data), .word_o(pk_word), .cnt_o(pk_cnt), .full_o(pk_full),
    .merged_word_o(mg_word), .merged_cnt_o(mg_cnt)
  );

  // the request register can take a new word once it is empty or being accepted now
  assign req_free  = !mem_write_q || !mem_waitrequest;
  assign pkt_ready = (state_q == IDLE || state_q == COLLECT) &&
                     !(mem_write_q && mem_waitrequest && pk_full);
  assign accept    = pkt_valid && pkt_ready;
  assign data_addr = base_q + ADDR_W'(HDR_BYTES) + (ADDR_W'(k_q) << 2);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    k_d         = k_q;
    trunc_d     = trunc_q;
    match_d     = match_q;
    mem_write_d = mem_write_q && mem_waitrequest;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byteen_d    = byteen_q;
    pk_clr      = 1'b0;
    pk_push     = 1'b0;
    pk_take     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && pkt_sop) begin
          base_d  = base_addr;
          len_d   = CNT_W'(1);
          k_d     = '0;
          trunc_d = 1'b0;
          pk_clr  = 1'b1;
          pk_push = 1'b1;
          match_d = pkt_match;
          state_d = pkt_eop ? FLUSH : COLLECT;
        end
      end
      COLLECT: begin
        // a word left waiting behind a stalled write moves out first
        if (pk_full && req_free) begin
          mem_write_d = 1'b1;
          addr_d      = data_addr;
          wdata_d     = DATA_W'(pk_word);
          byteen_d    = 4'hF;
          k_d         = k_q + CNT_W'(1);
          pk_clr      = 1'b1;
        end
        if (accept) begin
          if (pkt_sop) begin
            len_d   = CNT_W'(1);
            k_d     = '0;
            trunc_d = 1'b0;
            pk_clr  = 1'b1;
            pk_push = 1'b1;
          end else if (len_q < CNT_W'(MAX_PAYLOAD)) begin
            len_d   = len_q + CNT_W'(1);
            pk_push = 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
          if (mg_cnt == 3'd4 && req_free) begin
            mem_write_d = 1'b1;
            addr_d      = data_addr;
            wdata_d     = DATA_W'(mg_word);
            byteen_d    = 4'hF;
            k_d         = k_q + CNT_W'(1);
            pk_take     = 1'b1;
          end
          if (pkt_eop) begin
            match_d = pkt_match;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (req_free) begin
          if (pk_cnt != 3'd0) begin
            mem_write_d = 1'b1;
            addr_d      = data_addr;
            wdata_d     = DATA_W'(pk_word);
            byteen_d    = byteen_for(pk_cnt);
            k_d         = k_q + CNT_W'(1);
            pk_clr      = 1'b1;
          end else if (match_q) begin
            mem_write_d = 1'b1;
            addr_d      = base_q;
            wdata_d     = DATA_W'({16'h0, trunc_q, 15'(len_q)});
            byteen_d    = 4'hF;
            state_d     = HEADER;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HEADER: begin
        if (!mem_waitrequest) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      k_q         <= '0;
      trunc_q     <= 1'b0;
      match_q     <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      byteen_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      k_q         <= k_d;
      trunc_q     <= trunc_d;
      match_q     <= match_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byteen_q    <= byteen_d;
    end
  end

  assign mem_write     = mem_write_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_byteen    = byteen_q;
  assign inc_addr      = (state_q == DONE);
  assign pkt_truncated = (state_q == DONE) && trunc_q;

endmodule
